// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter with a start/busy/done handshake.
// Optional leading-zero blanking is enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [WIDTH-1:0]      bin_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [4*DIGITS-1:0]   bcd_o,
   output logic                  overflow_o,
   output logic [DIGITS-1:0]     blank_o
);

   // state | meaning
   // IDLE  | waiting for start_i, last result held on outputs
   // SHIFT | one input bit shifted into the BCD scratch per clock

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   function automatic int max_val();
      int v;
      v = 1;
      for (int i = 0; i < DIGITS; i++) v = v * 10;
      return v - 1;
   endfunction

   localparam logic [31:0] MAXV = 32'(max_val());

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          state;
   logic [WIDTH-1:0] sr;
   logic [BW-1:0]   scratch;
   logic [BW-1:0]   adj;
   logic [BW-1:0]   nxt;
   logic [BW-1:0]   load_val;
   logic [CW-1:0]   cnt;
   logic            cap_ovf;

   always_comb begin
      adj = scratch;
      for (int d = 0; d < DIGITS; d++) begin
         if (scratch[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
      nxt      = {adj[BW-2:0], sr[WIDTH-1]};
      load_val = cap_ovf ? {DIGITS{4'h9}} : nxt;
   end

`ifdef BIN2BCD_BLANK_EN
   // Bit k set when digit k and every higher digit are zero; units never blanked.
   function automatic logic [DIGITS-1:0] blank_of(input logic [BW-1:0] v);
      logic [DIGITS-1:0] b;
      logic              zero_above;
      b          = '0;
      zero_above = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_above = zero_above & (v[4*k +: 4] == 4'd0);
         b[k]       = zero_above;
      end
      b[0] = 1'b0;
      return b;
   endfunction
`else
   assign blank_o = '0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         sr         <= '0;
         scratch    <= '0;
         cnt        <= '0;
         cap_ovf    <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         bcd_o      <= '0;
         overflow_o <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
         blank_o    <= blank_of('0);
`endif
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  sr      <= bin_i;
                  scratch <= '0;
                  cnt     <= CW'(WIDTH);
                  cap_ovf <= (32'(bin_i) > MAXV);
                  busy_o  <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               scratch <= nxt;
               sr      <= sr << 1;
               cnt     <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state      <= IDLE;
                  busy_o     <= 1'b0;
                  done_o     <= 1'b1;
                  bcd_o      <= load_val;
                  overflow_o <= cap_ovf;
`ifdef BIN2BCD_BLANK_EN
                  blank_o    <= blank_of(load_val);
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed testbench for bin2bcd_seq: a 3-digit and a 2-digit instance, 8-bit input.
module tb_bin2bcd_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] bin = '0;
   logic       busy, done, ovf;
   logic [11:0] bcd;
   logic [2:0] blank;

   logic       start2 = 1'b0;
   logic [7:0] bin2 = '0;
   logic       busy2, done2, ovf2;
   logic [7:0] bcd2;
   logic [1:0] blank2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .bin_i(bin),
      .busy_o(busy), .done_o(done), .bcd_o(bcd), .overflow_o(ovf), .blank_o(blank)
   );

   bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
      .clk_i(clk), .rst_i(rst), .start_i(start2), .bin_i(bin2),
      .busy_o(busy2), .done_o(done2), .bcd_o(bcd2), .overflow_o(ovf2), .blank_o(blank2)
   );

`ifdef BIN2BCD_BLANK_EN
   localparam bit BLANK_ON = 1'b1;
`else
   localparam bit BLANK_ON = 1'b0;
`endif

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Request a conversion on the 3-digit instance and check handshake timing.
   task automatic convert(input logic [7:0] v, input string tag);
      int n;
      bin   = v;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (busy && n < 30) begin
         n++;
         tick();
      end
      check_val({tag, "_busy_cycles"}, n, 8);
      check_val({tag, "_done"}, done, 1);
   endtask

   function automatic logic [31:0] bexp(input logic [2:0] v);
      return BLANK_ON ? 32'(v) : 32'd0;
   endfunction

   initial begin
      int n;
      bit saw_done;

      tick(); tick();
      rst = 1'b0;
      check_val("rst_bcd", bcd, 12'h000);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_ovf", ovf, 0);
      check_val("rst_blank", blank, bexp(3'b110));
      check_val("rst_blank2", blank2, BLANK_ON ? 32'b10 : 32'b0);
      tick();
      check_val("idle_busy", busy, 0);

      convert(8'd255, "c255");
      check_val("c255_bcd", bcd, 12'h255);
      check_val("c255_ovf", ovf, 0);
      check_val("c255_blank", blank, 0);
      tick();
      check_val("c255_done_pulse", done, 0);
      check_val("c255_hold", bcd, 12'h255);

      convert(8'd7, "c7");
      check_val("c7_bcd", bcd, 12'h007);
      check_val("c7_blank", blank, bexp(3'b110));
      tick();

      convert(8'd40, "c40");
      check_val("c40_bcd", bcd, 12'h040);
      check_val("c40_blank", blank, bexp(3'b100));
      tick();

      convert(8'd0, "c0");
      check_val("c0_bcd", bcd, 12'h000);
      check_val("c0_blank", blank, bexp(3'b110));
      tick();

      // Two-digit instance: overflow saturates to 99, then a normal value.
      bin2 = 8'd150; start2 = 1'b1; tick(); start2 = 1'b0;
      repeat (8) tick();
      check_val("d2_150_done", done2, 1);
      check_val("d2_150_bcd", bcd2, 8'h99);
      check_val("d2_150_ovf", ovf2, 1);
      check_val("d2_150_blank", blank2, 0);
      tick();
      bin2 = 8'd42; start2 = 1'b1; tick(); start2 = 1'b0;
      repeat (8) tick();
      check_val("d2_42_done", done2, 1);
      check_val("d2_42_bcd", bcd2, 8'h42);
      check_val("d2_42_ovf", ovf2, 0);
      tick();
      bin2 = 8'd99; start2 = 1'b1; tick(); start2 = 1'b0;
      repeat (8) tick();
      check_val("d2_99_bcd", bcd2, 8'h99);
      check_val("d2_99_ovf", ovf2, 0);
      tick();
      bin2 = 8'd5; start2 = 1'b1; tick(); start2 = 1'b0;
      repeat (8) tick();
      check_val("d2_5_bcd", bcd2, 8'h05);
      check_val("d2_5_blank", blank2, BLANK_ON ? 32'b10 : 32'b0);
      tick();

      // Start during SHIFT ignored; start during done cycle accepted.
      bin = 8'd42; start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      bin = 8'd99; start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (!done && n < 30) begin
         n++;
         tick();
      end
      check_val("ign_done_seen", done, 1);
      check_val("ign_bcd", bcd, 12'h042);
      bin = 8'd100; start = 1'b1; tick(); start = 1'b0;
      check_val("b2b_busy", busy, 1);
      check_val("b2b_hold", bcd, 12'h042);
      repeat (8) tick();
      check_val("b2b_done", done, 1);
      check_val("b2b_bcd", bcd, 12'h100);
      check_val("b2b_blank", blank, 0);
      tick();

      // Reset in the 4th SHIFT cycle of converting 200.
      bin = 8'd200; start = 1'b1; tick(); start = 1'b0;
      tick(); tick(); tick();
      check_val("mid_busy", busy, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      check_val("mrst_busy", busy, 0);
      check_val("mrst_bcd", bcd, 12'h000);
      check_val("mrst_done", done, 0);
      check_val("mrst_blank", blank, bexp(3'b110));
      saw_done = 1'b0;
      repeat (12) begin
         tick();
         if (done || busy) saw_done = 1'b1;
      end
      check_val("mrst_no_done", saw_done, 0);
      check_val("mrst_bcd_hold", bcd, 12'h000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
